lvds_event_stamper: RTL and testbench



---
 rtl/lvds_event_stamper_pkg.sv | 18 +
 rtl/lvds_sync_edge.sv | 40 ++++
 rtl/lvds_event_stamper.sv | 123 ++++++++++++
 tb/tb_lvds_event_stamper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_event_stamper_pkg.sv
// Shared constants for the event stamper and the FIFO readout decode:
// ev_data = {channel[CH_W-1:0], timestamp[EV_TS_W-1:0]}.
package lvds_event_stamper_pkg;

    localparam int CH_W      = 4;
    localparam int EV_W      = 32;
    localparam int EV_TS_W   = EV_W - CH_W;
    localparam int EV_TS_LSB = 0;
    localparam int EV_TS_MSB = EV_TS_W - 1;
    localparam int EV_CH_LSB = EV_TS_W;
    localparam int EV_CH_MSB = EV_W - 1;

    function automatic logic [EV_W-1:0] pack_event(input logic [CH_W-1:0]    ch,
                                                   input logic [EV_TS_W-1:0] ts);
        return {ch, ts};
    endfunction

endpackage

// File: rtl/lvds_sync_edge.sv
// One hit line: 2-flop synchroniser, registered rising-edge detector, and an
// optional 2-cycle high qualifier (LVDS_GLITCH_FILTER_EN).
module lvds_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_det
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
`ifdef LVDS_GLITCH_FILTER_EN
    logic prev2_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            prev_reg  <= 1'b0;
            edge_det  <= 1'b0;
`ifdef LVDS_GLITCH_FILTER_EN
            prev2_reg <= 1'b0;
`endif
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
`ifdef LVDS_GLITCH_FILTER_EN
            // Qualify only after the line has stayed high for two synced cycles.
            prev2_reg <= prev_reg;
            edge_det  <= sync_reg & prev_reg & ~prev2_reg;
`else
            edge_det  <= sync_reg & ~prev_reg;
`endif
        end
    end

endmodule

// File: rtl/lvds_event_stamper.sv
// Hit capture front end: per-line edge detect, timestamp latch, round-robin
// serialisation into a 32-bit valid/ready stream. Optional: LVDS_GLITCH_FILTER_EN.
module lvds_event_stamper
    import lvds_event_stamper_pkg::*;
#(
    parameter int N_CH = 16,
    parameter int TS_W = 28
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] lvds,
    input  logic            trigger,
    input  logic            drop_clr,
    output logic            ev_valid,
    output logic [31:0]     ev_data,
    input  logic            ev_ready,
    output logic [15:0]     drop_cnt,
    output logic [N_CH-1:0] pending
);

    localparam logic [CH_W-1:0] LAST_GRANT_RST = CH_W'(N_CH - 1);

    logic [N_CH-1:0] edge_vec;
    logic [TS_W-1:0] ts_reg;
    logic [TS_W-1:0] ts_store [N_CH];
    logic [N_CH-1:0] pending_reg, pending_next;
    logic [CH_W-1:0] last_grant_reg;
    logic            ev_valid_reg;
    logic [EV_W-1:0] ev_data_reg;
    logic [15:0]     drop_cnt_reg;

    logic            grant_any;
    logic [CH_W-1:0] grant_idx;
    logic            load;
    logic [N_CH-1:0] grant_oh;
    logic [N_CH-1:0] capture_vec;
    logic [N_CH-1:0] drop_vec;
    logic [4:0]      drop_num;
    logic [16:0]     drop_sum;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            lvds_sync_edge u_sync (
                .clk      (clk),
                .rst_n    (rst_n),
                .din      (lvds[gi]),
                .edge_det (edge_vec[gi])
            );
            assign grant_oh[gi]    = load && (grant_idx == CH_W'(gi));
            // A held entry that is not leaving this cycle turns a new hit into a drop.
            assign capture_vec[gi] = edge_vec[gi] & trigger & (~pending_reg[gi] | grant_oh[gi]);
            assign drop_vec[gi]    = edge_vec[gi] & trigger & pending_reg[gi] & ~grant_oh[gi];
        end
    endgenerate

    // Round-robin: first pending channel strictly after last_grant, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_grant_reg) + i) % N_CH;
            if (!grant_any && pending_reg[idx]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    assign load         = grant_any & (~ev_valid_reg | ev_ready);
    assign pending_next = (pending_reg & ~grant_oh) | capture_vec;

    always_comb begin
        drop_num = '0;
        for (int c = 0; c < N_CH; c++) begin
            drop_num = drop_num + 5'(drop_vec[c]);
        end
        drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_num);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_reg         <= '0;
            pending_reg    <= '0;
            last_grant_reg <= LAST_GRANT_RST;
            ev_valid_reg   <= 1'b0;
            ev_data_reg    <= '0;
            drop_cnt_reg   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                ts_store[c] <= '0;
            end
        end else begin
            ts_reg      <= ts_reg + 1'b1;
            pending_reg <= pending_next;
            for (int c = 0; c < N_CH; c++) begin
                if (capture_vec[c]) begin
                    ts_store[c] <= ts_reg;
                end
            end
            if (load) begin
                ev_valid_reg   <= 1'b1;
                ev_data_reg    <= pack_event(grant_idx, ts_store[grant_idx]);
                last_grant_reg <= grant_idx;
            end else if (ev_ready) begin
                ev_valid_reg <= 1'b0;
            end
            if (drop_clr) begin
                drop_cnt_reg <= '0;
            end else if (drop_sum[16]) begin
                drop_cnt_reg <= 16'hFFFF;
            end else begin
                drop_cnt_reg <= drop_sum[15:0];
            end
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_data  = ev_data_reg;
    assign drop_cnt = drop_cnt_reg;
    assign pending  = pending_reg;

endmodule

// File: tb/tb_lvds_event_stamper.sv
// Directed bench for lvds_event_stamper: expected events are queued at stimulus
// time and a monitor pops and compares each accepted ev_data word.
module tb_lvds_event_stamper;
    import lvds_event_stamper_pkg::*;

    localparam int N_CH = 16;
    localparam int TS_W = 28;
`ifdef LVDS_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] lvds;
    logic            trigger;
    logic            drop_clr;
    logic            ev_valid;
    logic [31:0]     ev_data;
    logic            ev_ready;
    logic [15:0]     drop_cnt;
    logic [N_CH-1:0] pending;

    logic [31:0]     exp_q [$];
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [TS_W-1:0] model_ts;
    logic [TS_W-1:0] ts_a;
    logic [TS_W-1:0] ts_b;

    lvds_event_stamper #(.N_CH(N_CH), .TS_W(TS_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lvds     (lvds),
        .trigger  (trigger),
        .drop_clr (drop_clr),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .drop_cnt (drop_cnt),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: a word is accepted at the posedge following a cycle with valid & ready.
    always begin
        logic [31:0] exp_v;
        @(negedge clk);
        #1;
        if (rst_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got %h required none", ev_data);
            end else begin
                exp_v = exp_q.pop_front();
                $display("event ch=%0d ts=%h (expected ch=%0d ts=%h)",
                         ev_data[EV_CH_MSB:EV_CH_LSB], ev_data[EV_TS_MSB:EV_TS_LSB],
                         exp_v[EV_CH_MSB:EV_CH_LSB], exp_v[EV_TS_MSB:EV_TS_LSB]);
                check("event", ev_data, exp_v);
            end
        end
    end

    // Each step lands on a negedge; model_ts is the counter value for the coming cycle.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) model_ts = '0;
            else        model_ts = model_ts + 1'b1;
        end
    endtask

    task automatic expect_ev(input int ch, input logic [TS_W-1:0] ts);
        exp_q.push_back({4'(ch), ts});
    endtask

    task automatic pulse(input logic [N_CH-1:0] m, input int w);
        lvds = m;
        cyc(w);
        lvds = '0;
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        lvds     = '0;
        trigger  = 1'b0;
        drop_clr = 1'b0;
        ev_ready = 1'b1;
        model_ts = '0;
        cyc(3);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_data", ev_data, 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ts", 32'(dut.ts_reg), 32'd0);
        rst_n = 1'b1;
        cyc(98);

        // Single hit on ch0 near ts=100
        trigger = 1'b1;
        cyc(1);
        expect_ev(0, model_ts + TS_W'(LAT));
        pulse(16'h0001, 2);
        drain();
        check("t1_drop_cnt", 32'(drop_cnt), 32'd0);
        check("t1_valid_low", 32'(ev_valid), 32'd0);

        // Simultaneous hits drain 2,5,9 with one shared timestamp
        ts_a = model_ts + TS_W'(LAT);
        expect_ev(2, ts_a);
        expect_ev(5, ts_a);
        expect_ev(9, ts_a);
        pulse(16'h0224, 2);
        drain();

        // Trigger off: hit ignored; trigger on: one event
        trigger = 1'b0;
        pulse(16'h0008, 2);
        cyc(8);
        check("trig0_pending", 32'(pending), 32'd0);
        check("trig0_valid", 32'(ev_valid), 32'd0);
        trigger = 1'b1;
        cyc(1);
        expect_ev(3, model_ts + TS_W'(LAT));
        pulse(16'h0008, 2);
        drain();

        // Stall: ch7 holds the slot, second ch1 hit is dropped
        ev_ready = 1'b0;
        ts_b = model_ts + TS_W'(LAT);
        expect_ev(7, ts_b);
        pulse(16'h0080, 2);
        cyc(6);
        check("stall_valid", 32'(ev_valid), 32'd1);
        ts_a = model_ts + TS_W'(LAT);
        expect_ev(1, ts_a);
        pulse(16'h0002, 2);
        cyc(8);
        pulse(16'h0002, 2);
        cyc(6);
        check("drop_cnt_one", 32'(drop_cnt), 32'd1);
        check("drop_pending", 32'(pending), 32'h0002);
        check("stall_data_stable", ev_data, {4'd7, ts_b});
        ev_ready = 1'b1;
        drain();
        check("drop_valid_low", 32'(ev_valid), 32'd0);
        check("drop_cnt_held", 32'(drop_cnt), 32'd1);
        drop_clr = 1'b1;
        cyc(1);
        drop_clr = 1'b0;
        cyc(1);
        check("drop_cnt_clr", 32'(drop_cnt), 32'd0);

        // Timestamp wrap
        force dut.ts_reg = 28'hFFFFFFE;
        model_ts = 28'hFFFFFFE;
        expect_ev(4, model_ts + TS_W'(LAT));
        lvds = 16'h0010;
        #1;
        release dut.ts_reg;
        cyc(2);
        lvds = '0;
        drain();

        // Reset in mid-stream discards everything
        ev_ready = 1'b0;
        expect_ev(6, model_ts + TS_W'(LAT));
        pulse(16'h0040, 2);
        cyc(4);
        pulse(16'h3C00, 2);
        cyc(5);
        check("pre_rst_pending", 32'(pending), 32'h3C00);
        check("pre_rst_valid", 32'(ev_valid), 32'd1);
        rst_n = 1'b0;
        cyc(1);
        exp_q.delete();
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_valid", 32'(ev_valid), 32'd0);
        check("mid_rst_ts", 32'(dut.ts_reg), 32'd0);
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        trigger  = 1'b1;
        cyc(10);
        check("post_rst_valid", 32'(ev_valid), 32'd0);

`ifdef LVDS_GLITCH_FILTER_EN
        // 1-cycle glitch rejected, 2-cycle pulse accepted
        pulse(16'h0100, 1);
        cyc(8);
        check("glitch_pending", 32'(pending), 32'd0);
        check("glitch_valid", 32'(ev_valid), 32'd0);
        expect_ev(8, model_ts + TS_W'(LAT));
        pulse(16'h0100, 2);
        drain();
`else
        // Minimum-width 1-cycle pulse still yields one event
        expect_ev(8, model_ts + TS_W'(LAT));
        pulse(16'h0100, 1);
        drain();
        check("min_pulse_pending", 32'(pending), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
